// File: rtl/seg7_capture_pkg.sv
// seg7_capture_pkg
//   Shared 7-segment definitions. The display encoder and this receiver both
//   use them, so the two ends of the display bus always agree.
//   Segment pattern layout is {a,b,c,d,e,f,g}: bit 6 = a ... bit 0 = g, and
//   segments are active high.
package seg7_capture_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Legal hex-digit patterns
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h47;

endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex
//   Combinational decode of a 7-segment pattern back to a hex nibble.
//   Ports:
//     seg    in  7  segment pattern {a..g}, active high
//     nibble out 4  decoded value (0 when the pattern is illegal)
//     legal  out 1  pattern is one of the 16 hex codes
module seg7_to_hex
    import seg7_capture_pkg::*;
(
    input  logic [SEG_W-1:0]    seg,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture
//   Samples a multiplexed 7-segment display bus, waits for each digit pattern
//   to be stable for STABLE_CYCLES samples, decodes it and assembles a word.
//   When every digit has been captured, the word is offered on a valid/ready
//   output slot.
//   Ports:
//     clock     in   system clock, rising edge
//     reset     in   synchronous, active-high
//     seg_in    in   segment pattern {a..g}, bit 6 = a
//     dig_sel   in   one-hot digit select, bit i = digit i
//     out_value out  captured word, nibble i = digit i
//     out_err   out  per-digit illegal-pattern flag
//     out_valid out  out_value/out_err hold a frame
//     out_ready in   consumer accepts the frame
//     overrun   out  sticky: a frame completed while the previous one was pending
module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SEG_W-1:0]             seg_in,
    input  logic [DIGITS-1:0]            dig_sel,
    output logic [NIBBLE_W*DIGITS-1:0]   out_value,
    output logic [DIGITS-1:0]            out_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]            seg_p0;
    logic [DIGITS-1:0]           sel_p0;
    logic [CNT_W-1:0]            cnt_p0;

    logic [NIBBLE_W*DIGITS-1:0]  frame_buf;
    logic [DIGITS-1:0]           seen;
    logic [DIGITS-1:0]           err;

    logic [NIBBLE_W-1:0]         dec_nibble;
    logic                        dec_legal;

    logic                        stable;
    logic                        capture;
    logic                        frame_full;
    logic                        slot_free;

    seg7_to_hex u_dec (
        .seg    (seg_in),
        .nibble (dec_nibble),
        .legal  (dec_legal)
    );

    // A sample counts towards stability only if it matches the previous one
    // and exactly one digit is selected.
    assign stable     = (seg_in == seg_p0) && (dig_sel == sel_p0) && $onehot(dig_sel);
    // Fires only on the step into the saturated value, so a held pattern
    // captures exactly once.
    assign capture    = stable && (cnt_p0 == CNT_ARM);
    assign frame_full = &seen;
    assign slot_free  = !out_valid || out_ready;

    // Stage p0: input register and stability counter
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_p0 <= '0;
            sel_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            seg_p0 <= seg_in;
            sel_p0 <= dig_sel;
            if (!stable) begin
                cnt_p0 <= '0;
            end else if (cnt_p0 != CNT_MAX) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // Stage p1: frame buffer and output slot
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_buf <= '0;
            seen      <= '0;
            err       <= '0;
            out_value <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (frame_full) begin
                // A completed frame blocks further captures until it moves
                // into the output slot; a load here overrides the drop above.
                if (slot_free) begin
                    out_value <= frame_buf;
                    out_err   <= err;
                    out_valid <= 1'b1;
                    frame_buf <= '0;
                    seen      <= '0;
                    err       <= '0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        frame_buf[NIBBLE_W*i +: NIBBLE_W] <= dec_nibble;
                        seen[i]                           <= 1'b1;
                        err[i]                            <= !dec_legal;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture
//   Scoreboard bench for seg7_capture (DIGITS=4, STABLE_CYCLES=8). Stimulus
//   pushes hand-computed frames into a queue; a monitor pops and compares on
//   every accepted output transfer.
module tb_seg7_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  err;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    seg7_capture #(
        .DIGITS        (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] e);
        frame_t f;
        f.value = v;
        f.err   = e;
        exp_q.push_back(f);
    endtask

    // Called just after a rising edge; leaves the bench just after the
    // n-th following rising edge.
    task automatic show(input int d, input logic [6:0] p, input int n);
        seg_in  = p;
        dig_sel = 4'(1 << d);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic blank(input int n);
        seg_in  = 7'h00;
        dig_sel = 4'b0000;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Every negedge with valid && ready precedes exactly one transfer edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame actual=%0h/%0h required=none", out_value, out_err);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_value", 32'(out_value), 32'(f.value));
                check("frame_err",   32'(out_err),   32'(f.err));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        seg_in    = 7'h00;
        dig_sel   = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_value",   32'(out_value), 32'h0);
        check("reset_err",     32'(out_err),   32'h0);
        check("reset_valid",   32'(out_valid), 32'h0);
        check("reset_overrun", 32'(overrun),   32'h0);

        // Basic scan: F, A, 2, 1
        push(16'h12AF, 4'b0000);
        show(0, 7'h47, 10);
        show(1, 7'h77, 10);
        show(2, 7'h6D, 10);
        show(3, 7'h30, 10);
        blank(5);
        check("no_overrun_basic", 32'(overrun), 32'h0);

        // Digit1 held only 7 samples: frame waits until it is held long enough
        show(0, 7'h7E, 10);
        show(1, 7'h30, 7);
        show(2, 7'h6D, 10);
        show(3, 7'h79, 10);
        blank(5);
        push(16'h3210, 4'b0000);
        show(1, 7'h30, 10);
        blank(5);

        // Illegal pattern on digit2
        push(16'h406E, 4'b0100);
        show(0, 7'h4F, 10);
        show(1, 7'h5F, 10);
        show(2, 7'h3E, 10);
        show(3, 7'h33, 10);
        blank(5);

        // Digit0 re-captured within one frame: latest wins
        push(16'hF07E, 4'b0000);
        show(0, 7'h5B, 10);
        show(0, 7'h4F, 10);
        show(1, 7'h70, 10);
        show(2, 7'h7E, 10);
        show(3, 7'h47, 10);
        blank(5);

        // Back-pressure: two full scans with the consumer stalled
        out_ready = 1'b0;
        push(16'h4321, 4'b0000);
        push(16'h8765, 4'b0000);
        show(0, 7'h30, 10);
        show(1, 7'h6D, 10);
        show(2, 7'h79, 10);
        show(3, 7'h33, 10);
        check("stall_valid_first", 32'(out_valid), 32'h1);
        show(0, 7'h5B, 10);
        show(1, 7'h5F, 10);
        show(2, 7'h70, 10);
        show(3, 7'h7F, 10);
        blank(5);
        check("stall_valid",   32'(out_valid), 32'h1);
        check("stall_hold",    32'(out_value), 32'h4321);
        check("stall_overrun", 32'(overrun),   32'h1);
        out_ready = 1'b1;
        blank(5);
        check("drain_valid_low", 32'(out_valid), 32'h0);
        check("overrun_sticky",  32'(overrun),   32'h1);

        // Two digits selected at once never capture
        push(16'hABCD, 4'b0000);
        show(0, 7'h3D, 10);
        show(1, 7'h4E, 10);
        show(2, 7'h1F, 10);
        seg_in  = 7'h4F;
        dig_sel = 4'b0011;
        repeat (20) @(posedge clock);
        #1;
        show(3, 7'h77, 10);
        blank(5);

        // Reset mid-scan discards the partial frame and the held output
        show(0, 7'h7E, 10);
        show(1, 7'h30, 5);
        pulse_reset(2);
        check("midreset_value",   32'(out_value), 32'h0);
        check("midreset_err",     32'(out_err),   32'h0);
        check("midreset_valid",   32'(out_valid), 32'h0);
        check("midreset_overrun", 32'(overrun),   32'h0);
        show(2, 7'h77, 10);
        show(3, 7'h1F, 10);
        show(1, 7'h7F, 10);
        blank(5);
        push(16'hBA89, 4'b0000);
        show(0, 7'h7B, 10);
        blank(10);

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
